// File: rtl/up_control_sequencer_if.sv
// Control-unit bus for the 4-bit micro: decode inputs from FETCH/datapath and
// the strobes the sequencer drives back into PC, ALU, RAM and the IO ports.
interface up_control_sequencer_if;
  logic       run;
  logic [3:0] instr;
  logic       c_flag;
  logic       z_flag;
  logic       in_valid;

  logic       pc_en;
  logic       pc_load;
  logic       fetch_en;
  logic       acc_load;
  logic       flag_load;
  logic [2:0] alu_op;
  logic       alu_src;
  logic       ram_cs;
  logic       ram_we;
  logic       out_en;
  logic       in_ready;
  logic       in_timeout;
  logic       halted;
  logic [1:0] state_o;

  // Sequencer side.
  modport master (
    input  run, instr, c_flag, z_flag, in_valid,
    output pc_en, pc_load, fetch_en, acc_load, flag_load, alu_op, alu_src,
           ram_cs, ram_we, out_en, in_ready, in_timeout, halted, state_o
  );

  // Datapath / environment side.
  modport slave (
    output run, instr, c_flag, z_flag, in_valid,
    input  pc_en, pc_load, fetch_en, acc_load, flag_load, alu_op, alu_src,
           ram_cs, ram_we, out_en, in_ready, in_timeout, halted, state_o
  );
endinterface

// File: rtl/up_control_sequencer.sv
// FETCH/EXEC sequencer for the 4-bit micro with IN-port wait and terminal HALT.
// Strobes are Mealy (state + inputs); the datapath samples them on the next edge.
module up_control_sequencer #(
  parameter int unsigned IN_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  up_control_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_IN = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_JC    = 4'h1;
  localparam logic [3:0] OP_JNC   = 4'h2;
  localparam logic [3:0] OP_JZ    = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_LIT   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_NANDI = 4'h7;
  localparam logic [3:0] OP_CMPI  = 4'h8;
  localparam logic [3:0] OP_LD    = 4'h9;
  localparam logic [3:0] OP_ST    = 4'hA;
  localparam logic [3:0] OP_OUT   = 4'hB;
  localparam logic [3:0] OP_IN    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  // Values above 255 are truncated to the 8-bit counter range.
  localparam bit         TIMEOUT_EN   = (IN_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(IN_TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] timeout_cnt_reg;

  logic       branch_taken;
  logic       timeout_hit;

  logic       pc_en_next;
  logic       pc_load_next;
  logic       fetch_en_next;
  logic       acc_load_next;
  logic       flag_load_next;
  logic [2:0] alu_op_next;
  logic       alu_src_next;
  logic       ram_cs_next;
  logic       ram_we_next;
  logic       out_en_next;
  logic       in_ready_next;
  logic       in_timeout_next;
  logic       halted_next;

  always_comb begin
    branch_taken = 1'b0;
    case (bus.instr)
      OP_JC:   branch_taken = bus.c_flag;
      OP_JNC:  branch_taken = ~bus.c_flag;
      OP_JZ:   branch_taken = bus.z_flag;
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  // A valid word arriving on the last allowed cycle still wins over the abort.
  assign timeout_hit = TIMEOUT_EN && (timeout_cnt_reg == TIMEOUT_LAST) && !bus.in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      timeout_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.run) begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          timeout_cnt_reg <= 8'd0;
          if (bus.instr == OP_IN && !bus.in_valid) begin
            state_reg <= S_WAIT_IN;
          end else if (bus.instr == OP_HALT) begin
            state_reg <= S_HALT;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (bus.in_valid || timeout_hit) begin
            state_reg       <= S_FETCH;
            timeout_cnt_reg <= 8'd0;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    pc_en_next      = 1'b0;
    pc_load_next    = 1'b0;
    fetch_en_next   = 1'b0;
    acc_load_next   = 1'b0;
    flag_load_next  = 1'b0;
    alu_op_next     = ALU_PASS_B;
    alu_src_next    = 1'b0;
    ram_cs_next     = 1'b0;
    ram_we_next     = 1'b0;
    out_en_next     = 1'b0;
    in_ready_next   = 1'b0;
    in_timeout_next = 1'b0;
    halted_next     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (bus.run) begin
          fetch_en_next = 1'b1;
          pc_en_next    = 1'b1;
        end
      end
      S_EXEC: begin
        case (bus.instr)
          // Not-taken branches still step over the address byte.
          OP_JC, OP_JNC, OP_JZ, OP_JMP: begin
            pc_load_next = branch_taken;
            pc_en_next   = ~branch_taken;
          end
          OP_LIT: begin
            acc_load_next = 1'b1;
            alu_op_next   = ALU_PASS_B;
          end
          OP_ADDI: begin
            acc_load_next  = 1'b1;
            flag_load_next = 1'b1;
            alu_op_next    = ALU_ADD;
          end
          OP_NANDI: begin
            acc_load_next  = 1'b1;
            flag_load_next = 1'b1;
            alu_op_next    = ALU_NAND;
          end
          OP_CMPI: begin
            flag_load_next = 1'b1;
            alu_op_next    = ALU_SUB;
          end
          OP_LD: begin
            ram_cs_next   = 1'b1;
            acc_load_next = 1'b1;
            alu_op_next   = ALU_PASS_B;
            alu_src_next  = 1'b1;
          end
          OP_ST: begin
            ram_cs_next = 1'b1;
            ram_we_next = 1'b1;
          end
          OP_OUT: begin
            out_en_next = 1'b1;
          end
          OP_IN: begin
            if (bus.in_valid) begin
              acc_load_next = 1'b1;
              alu_op_next   = ALU_PASS_B;
              alu_src_next  = 1'b1;
              in_ready_next = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      S_WAIT_IN: begin
        in_ready_next = 1'b1;
        if (bus.in_valid) begin
          acc_load_next = 1'b1;
          alu_op_next   = ALU_PASS_B;
          alu_src_next  = 1'b1;
        end else if (timeout_hit) begin
          in_timeout_next = 1'b1;
        end
      end
      S_HALT: begin
        halted_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset masks every output combinationally so it takes effect mid-cycle.
  assign bus.pc_en      = pc_en_next      & ~reset;
  assign bus.pc_load    = pc_load_next    & ~reset;
  assign bus.fetch_en   = fetch_en_next   & ~reset;
  assign bus.acc_load   = acc_load_next   & ~reset;
  assign bus.flag_load  = flag_load_next  & ~reset;
  assign bus.alu_op     = reset ? 3'b000 : alu_op_next;
  assign bus.alu_src    = alu_src_next    & ~reset;
  assign bus.ram_cs     = ram_cs_next     & ~reset;
  assign bus.ram_we     = ram_we_next     & ~reset;
  assign bus.out_en     = out_en_next     & ~reset;
  assign bus.in_ready   = in_ready_next   & ~reset;
  assign bus.in_timeout = in_timeout_next & ~reset;
  assign bus.halted     = halted_next     & ~reset;
  assign bus.state_o    = reset ? 2'd0 : state_reg;

endmodule

// File: tb/tb_up_control_sequencer.sv
// Bench for up_control_sequencer: fixed vector table, hand corner sequences and
// random stimulus, two instances (IN_TIMEOUT=0 and IN_TIMEOUT=4) against a model.
module tb_up_control_sequencer;

  typedef struct packed {
    logic       pc_en;
    logic       pc_load;
    logic       fetch_en;
    logic       acc_load;
    logic       flag_load;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ram_cs;
    logic       ram_we;
    logic       out_en;
    logic       in_ready;
    logic       in_timeout;
    logic       halted;
    logic [1:0] st;
  } outs_t;

  typedef struct packed {
    logic       run;
    logic [3:0] instr;
    logic       c;
    logic       z;
    logic       iv;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic       drv_run = 1'b0;
  logic [3:0] drv_instr = 4'h0;
  logic       drv_c = 1'b0;
  logic       drv_z = 1'b0;
  logic       drv_iv = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  up_control_sequencer_if bus0 ();
  up_control_sequencer_if bus4 ();

  assign bus0.run = drv_run;   assign bus4.run = drv_run;
  assign bus0.instr = drv_instr; assign bus4.instr = drv_instr;
  assign bus0.c_flag = drv_c;  assign bus4.c_flag = drv_c;
  assign bus0.z_flag = drv_z;  assign bus4.z_flag = drv_z;
  assign bus0.in_valid = drv_iv; assign bus4.in_valid = drv_iv;

  up_control_sequencer #(.IN_TIMEOUT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  up_control_sequencer #(.IN_TIMEOUT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  outs_t act0, act4, last0, last4;
  assign act0 = {bus0.pc_en, bus0.pc_load, bus0.fetch_en, bus0.acc_load, bus0.flag_load,
                 bus0.alu_op, bus0.alu_src, bus0.ram_cs, bus0.ram_we, bus0.out_en,
                 bus0.in_ready, bus0.in_timeout, bus0.halted, bus0.state_o};
  assign act4 = {bus4.pc_en, bus4.pc_load, bus4.fetch_en, bus4.acc_load, bus4.flag_load,
                 bus4.alu_op, bus4.alu_src, bus4.ram_cs, bus4.ram_we, bus4.out_en,
                 bus4.in_ready, bus4.in_timeout, bus4.halted, bus4.state_o};

  // Reference model: phase 0=fetch 1=exec 2=waiting for IN 3=halted,
  // plus the number of completed waiting cycles.
  int    m_phase[2];
  int    m_waited[2];
  int    timeout_of[2] = '{0, 4};
  outs_t exec_tab[16];
  outs_t in_load;

  function automatic outs_t ox(input logic pe, input logic pl, input logic fe, input logic al,
                               input logic fl, input logic [2:0] op, input logic src,
                               input logic cs, input logic we, input logic oe, input logic rdy,
                               input logic to, input logic h, input logic [1:0] st);
    return {pe, pl, fe, al, fl, op, src, cs, we, oe, rdy, to, h, st};
  endfunction

  function automatic vec_t v(input logic r, input logic [3:0] i, input logic c,
                             input logic z, input logic iv, input outs_t e);
    return {r, i, c, z, iv, e};
  endfunction

  function automatic outs_t model_out(input int d);
    outs_t o;
    logic  taken;
    o = '0;
    case (m_phase[d])
      0: if (drv_run) begin o.fetch_en = 1'b1; o.pc_en = 1'b1; end
      1: begin
        if (drv_instr >= 4'h1 && drv_instr <= 4'h4) begin
          taken = (drv_instr == 4'h4) || (drv_instr == 4'h1 && drv_c) ||
                  (drv_instr == 4'h2 && !drv_c) || (drv_instr == 4'h3 && drv_z);
          o.pc_load = taken;
          o.pc_en   = !taken;
        end else if (drv_instr == 4'hC) begin
          if (drv_iv) o = in_load;
        end else begin
          o = exec_tab[drv_instr];
        end
      end
      2: begin
        if (drv_iv) o = in_load;
        else begin
          o.in_ready = 1'b1;
          o.in_timeout = (timeout_of[d] != 0) && (m_waited[d] + 1 == timeout_of[d]);
        end
      end
      default: o.halted = 1'b1;
    endcase
    o.st = 2'(m_phase[d]);
    return o;
  endfunction

  function automatic void model_step(input int d);
    case (m_phase[d])
      0: if (drv_run) m_phase[d] = 1;
      1: begin
        m_waited[d] = 0;
        if (drv_instr == 4'hC && !drv_iv) m_phase[d] = 2;
        else if (drv_instr == 4'hF) m_phase[d] = 3;
        else m_phase[d] = 0;
      end
      2: begin
        m_waited[d] = m_waited[d] + 1;
        if (drv_iv || (timeout_of[d] != 0 && m_waited[d] == timeout_of[d])) begin
          m_phase[d] = 0;
          m_waited[d] = 0;
        end
      end
      default: m_phase[d] = 3;
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_waited[d] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic r, input logic [3:0] i, input logic c,
                       input logic z, input logic iv);
    drv_run = r; drv_instr = i; drv_c = c; drv_z = z; drv_iv = iv;
    #1;
    last0 = act0;
    last4 = act4;
    chk("model_t0", last0, model_out(0));
    chk("model_t4", last4, model_out(1));
    $display("cyc run=%0b instr=%h c=%0b z=%0b iv=%0b -> t0=%h t4=%h", r, i, c, z, iv, last0, last4);
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  // Reset raised between edges must clear every output without waiting for clk.
  task automatic async_reset(input string name);
    #2 reset = 1'b1;
    #1;
    chk({name, "_t0"}, act0, 32'd0);
    chk({name, "_t4"}, act4, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    outs_t f, e1;
    int halt_run;

    for (int k = 0; k < 16; k++) exec_tab[k] = '0;
    exec_tab[5].acc_load = 1'b1;
    exec_tab[6].acc_load = 1'b1; exec_tab[6].flag_load = 1'b1; exec_tab[6].alu_op = 3'b010;
    exec_tab[7].acc_load = 1'b1; exec_tab[7].flag_load = 1'b1; exec_tab[7].alu_op = 3'b100;
    exec_tab[8].flag_load = 1'b1; exec_tab[8].alu_op = 3'b011;
    exec_tab[9].ram_cs = 1'b1; exec_tab[9].acc_load = 1'b1; exec_tab[9].alu_src = 1'b1;
    exec_tab[10].ram_cs = 1'b1; exec_tab[10].ram_we = 1'b1;
    exec_tab[11].out_en = 1'b1;
    in_load = '0;
    in_load.acc_load = 1'b1; in_load.alu_src = 1'b1; in_load.in_ready = 1'b1;
    model_reset();

    f = ox(1,0,1,0,0,3'b000,0,0,0,0,0,0,0,2'd0);
    tbl.push_back(v(1,4'h5,0,0,0,f));
    tbl.push_back(v(1,4'h5,0,0,0,ox(0,0,0,1,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h1,1,0,0,f));
    tbl.push_back(v(1,4'h1,1,0,0,ox(0,1,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h1,0,0,0,f));
    tbl.push_back(v(1,4'h1,0,0,0,ox(1,0,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h4,0,0,0,f));
    tbl.push_back(v(1,4'h4,0,0,0,ox(0,1,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h4,1,1,0,f));
    tbl.push_back(v(1,4'h4,1,1,0,ox(0,1,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h2,1,0,0,f));
    tbl.push_back(v(1,4'h2,1,0,0,ox(1,0,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h2,0,1,0,f));
    tbl.push_back(v(1,4'h2,0,1,0,ox(0,1,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h3,0,1,0,f));
    tbl.push_back(v(1,4'h3,0,1,0,ox(0,1,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h3,1,0,0,f));
    tbl.push_back(v(1,4'h3,1,0,0,ox(1,0,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h6,0,0,0,f));
    tbl.push_back(v(1,4'h6,0,0,0,ox(0,0,0,1,1,3'b010,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h8,0,0,0,f));
    tbl.push_back(v(1,4'h8,0,0,0,ox(0,0,0,0,1,3'b011,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h7,0,0,0,f));
    tbl.push_back(v(1,4'h7,0,0,0,ox(0,0,0,1,1,3'b100,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h9,0,0,0,f));
    tbl.push_back(v(1,4'h9,0,0,0,ox(0,0,0,1,0,3'b000,1,1,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'hA,0,0,0,f));
    tbl.push_back(v(1,4'hA,0,0,0,ox(0,0,0,0,0,3'b000,0,1,1,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'hB,0,0,0,f));
    tbl.push_back(v(1,4'hB,0,0,0,ox(0,0,0,0,0,3'b000,0,0,0,1,0,0,0,2'd1)));
    tbl.push_back(v(1,4'hC,0,0,1,f));
    tbl.push_back(v(1,4'hC,0,0,1,ox(0,0,0,1,0,3'b000,1,0,0,0,1,0,0,2'd1)));
    tbl.push_back(v(1,4'hD,1,1,0,f));
    tbl.push_back(v(1,4'hD,1,1,0,ox(0,0,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(1,4'h0,0,0,0,f));
    tbl.push_back(v(1,4'h0,0,0,0,ox(0,0,0,0,0,3'b000,0,0,0,0,0,0,0,2'd1)));
    tbl.push_back(v(0,4'h5,0,0,0,'0));
    tbl.push_back(v(0,4'h5,0,0,0,'0));

    // Reset state: every output low while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_t0", act0, 32'd0);
    chk("reset_t4", act4, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) begin
      cycle(tbl[k].run, tbl[k].instr, tbl[k].c, tbl[k].z, tbl[k].iv);
      chk($sformatf("table%0d_t0", k), last0, tbl[k].exp);
      chk($sformatf("table%0d_t4", k), last4, tbl[k].exp);
    end

    // IN with in_valid low 5 waiting cycles, high on the 6th.
    cycle(1, 4'hC, 0, 0, 0);
    cycle(1, 4'hC, 0, 0, 0);
    chk("in_exec_ready", last0.in_ready, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1, 4'hC, 0, 0, k == 6);
      chk($sformatf("wait%0d_ready", k), last0.in_ready, 1'b1);
      chk($sformatf("wait%0d_acc", k), last0.acc_load, k == 6);
      chk($sformatf("wait%0d_to4", k), last4.in_timeout, k == 4);
      if (k <= 4) chk($sformatf("wait%0d_acc4", k), last4.acc_load, 1'b0);
    end
    cycle(0, 4'h0, 0, 0, 0);
    chk("after_in_state", last0.st, 2'd0);

    // HALT ignores run; only reset leaves it.
    cycle(1, 4'hF, 0, 0, 0);
    cycle(1, 4'hF, 0, 0, 0);
    e1 = ox(0,0,0,0,0,3'b000,0,0,0,0,0,0,1,2'd3);
    for (int k = 0; k < 6; k++) begin
      cycle(k[0], 4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom));
      chk($sformatf("halt%0d_t0", k), last0, e1);
      chk($sformatf("halt%0d_t4", k), last4, e1);
    end
    async_reset("halt_rst");
    cycle(0, 4'h0, 0, 0, 0);
    chk("post_halt_state", last0.st, 2'd0);
    chk("post_halt_halted", last0.halted, 1'b0);

    // run=0 stalls in FETCH with no strobes.
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'h5, 1, 1, 1);
      chk($sformatf("stall%0d", k), last0, 32'd0);
    end

    // Reset raised in the middle of WAIT_IN.
    cycle(1, 4'hC, 0, 0, 0);
    cycle(1, 4'hC, 0, 0, 0);
    cycle(1, 4'hC, 0, 0, 0);
    chk("wait_before_rst", last0.st, 2'd2);
    async_reset("wait_rst");

    // Random stimulus against the model.
    halt_run = 0;
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(7) != 0), 4'($urandom_range(15)), 1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0));
      halt_run = (m_phase[0] == 3) ? halt_run + 1 : 0;
      if (halt_run > 3 || $urandom_range(63) == 0) begin
        async_reset("rand_rst");
        halt_run = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
